gene_scan_ctrl: RTL

GENE_SCAN_CTRL -- requirements
Module: gene_scan_ctrl

---
 rtl/gene_scan_ctrl_pkg.sv | 18 +
 rtl/gene_skid_buf.sv | 46 ++++
 rtl/gene_scan_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/gene_scan_ctrl_pkg.sv
// Shared defaults, gene field offsets and FSM encoding for the genome scan controller.
package gene_scan_ctrl_pkg;
  localparam int GENE_SZ_DEF = 64;
  localparam int ATTR_SZ_DEF = 8;

  localparam int NODE_ID_LSB = 5 * ATTR_SZ_DEF;
  localparam int NODE_ID_MSB = 6 * ATTR_SZ_DEF - 1;
  localparam int LAYER_LSB   = 7 * ATTR_SZ_DEF - 3;
  localparam int LAYER_MSB   = 7 * ATTR_SZ_DEF - 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PASS0  = 3'd1,
    SWITCH = 3'd2,
    PASS1  = 3'd3,
    FIN    = 3'd4
  } scan_state_t;
endpackage

// File: rtl/gene_skid_buf.sv
// Two-entry gene buffer with same-cycle bypass when empty; zero latency for an empty buffer.
// Caller guarantees no push into a full buffer; flush wins over push/pop.
module gene_skid_buf #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [1:0]   count,
  output logic         out_vld,
  output logic [W-1:0] out_dat
);
  logic [W-1:0] mem [2];
  logic         wr_ptr, rd_ptr;
  logic         empty, store, take;

  assign empty   = (count == 2'd0);
  assign store   = push && !(pop && empty);
  assign take    = pop && !empty;
  assign out_vld = !empty || push;
  assign out_dat = !empty ? mem[rd_ptr] : (push ? push_dat : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (flush) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (store) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (take) rd_ptr <= ~rd_ptr;
      count <= count + 2'(store) - 2'(take);
    end
  end
endmodule

// File: rtl/gene_scan_ctrl.sv
// Two-pass genome scan: reads genes 0..len-1 twice (state=0 then 1), start->first gene in 2 cycles.
// Reads are credit-limited by the 2-entry buffer under gene_ready backpressure; GENE_SCAN_PERF_EN adds a stall counter.
module gene_scan_ctrl
  import gene_scan_ctrl_pkg::*;
#(
  parameter int GENE_SZ = GENE_SZ_DEF,
  parameter int ATTR_SZ = ATTR_SZ_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [ATTR_SZ-1:0] genome_len,
  output logic               mem_rd_en,
  output logic [ATTR_SZ-1:0] mem_addr,
  input  logic [GENE_SZ-1:0] mem_rd_data,
  output logic [GENE_SZ-1:0] gene_out,
  output logic               gene_valid,
  input  logic               gene_ready,
  output logic               state,
  output logic               busy,
  output logic               done,
  output logic [15:0]        stall_cnt
);
  scan_state_t        fsm;
  logic [ATTR_SZ-1:0] len_q, rd_cnt, xfer_cnt;
  logic               rd_pend, in_pass, buf_vld, xfer, last_xfer, kill, can_issue;
  logic [1:0]         buf_cnt;
  logic [2:0]         occ_nxt;

  assign in_pass    = (fsm == PASS0) || (fsm == PASS1);
  assign kill       = abort && (fsm != IDLE);
  assign gene_valid = in_pass && buf_vld;
  assign xfer       = gene_valid && gene_ready;
  assign last_xfer  = xfer && (xfer_cnt == len_q - ATTR_SZ'(1));
  assign busy       = (fsm != IDLE);
  // Occupancy seen next cycle: entries after this cycle's push/pop plus the read issued now.
  assign occ_nxt    = 3'(buf_cnt) + 3'(rd_pend) + 3'(mem_rd_en) - 3'(xfer);
  assign can_issue  = (rd_cnt != len_q) && (occ_nxt < 3'd2);

  gene_skid_buf #(.W(GENE_SZ)) u_buf (
    .clk      (clk),
    .rst      (rst),
    .flush    (kill),
    .push     (rd_pend),
    .push_dat (mem_rd_data),
    .pop      (xfer),
    .count    (buf_cnt),
    .out_vld  (buf_vld),
    .out_dat  (gene_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm       <= IDLE;
      len_q     <= '0;
      rd_cnt    <= '0;
      xfer_cnt  <= '0;
      rd_pend   <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      state     <= 1'b0;
      done      <= 1'b0;
    end else begin
      rd_pend   <= mem_rd_en && !kill;
      mem_rd_en <= 1'b0;
      done      <= 1'b0;
      if (kill) begin
        fsm   <= IDLE;
        state <= 1'b0;
      end else begin
        case (fsm)
          IDLE: if (start) begin
            len_q    <= genome_len;
            xfer_cnt <= '0;
            if (genome_len != '0) begin
              fsm       <= PASS0;
              mem_rd_en <= 1'b1;
              mem_addr  <= '0;
              rd_cnt    <= ATTR_SZ'(1);
            end else begin
              fsm  <= FIN;
              done <= 1'b1;
            end
          end
          PASS0, PASS1: begin
            if (xfer) xfer_cnt <= xfer_cnt + ATTR_SZ'(1);
            if (can_issue) begin
              mem_rd_en <= 1'b1;
              mem_addr  <= rd_cnt;
              rd_cnt    <= rd_cnt + ATTR_SZ'(1);
            end
            if (last_xfer) begin
              fsm  <= (fsm == PASS0) ? SWITCH : FIN;
              done <= (fsm == PASS1);
            end
          end
          SWITCH: begin
            fsm       <= PASS1;
            state     <= 1'b1;
            xfer_cnt  <= '0;
            mem_rd_en <= 1'b1;
            mem_addr  <= '0;
            rd_cnt    <= ATTR_SZ'(1);
          end
          FIN: begin
            fsm   <= IDLE;
            state <= 1'b0;
          end
          default: fsm <= IDLE;
        endcase
      end
    end
  end

`ifdef GENE_SCAN_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= 16'd0;
    else if (fsm == IDLE && start)
      stall_cnt <= 16'd0;
    else if (gene_valid && !gene_ready && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`else
  assign stall_cnt = 16'd0;
`endif
endmodule
